mem_port_arbiter: RTL and testbench

Sequencing controller and arbiter for the single-port, byte-wide data memory. It shares the memory between the instruction-fetch port and the load/store port. Each word, halfword or byte access is broken into consecutive little-endian byte cycles. Load results are sign- or zero-extended per RV32I funct3. Misaligned and illegal requests are rejected without touching memory.

---
 rtl/mem_port_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter and byte sequencer sharing a byte-wide synchronous-read memory
// between the instruction-fetch port and the load/store port. Each access is
// split into little-endian byte cycles; loads are extended according to the
// RV32I funct3. Illegal or misaligned requests are answered without touching
// memory.
module mem_port_arbiter #(
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [31:0]       if_rdata,
   output logic              if_ack,
   output logic              if_err,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [2:0]        d_funct3,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [31:0]       d_wdata,
   output logic [31:0]       d_rdata,
   output logic              d_ack,
   output logic              d_err,
   output logic              m_en,
   output logic              m_we,
   output logic [ADDR_W-1:0] m_addr,
   output logic [7:0]        m_wdata,
   input  logic [7:0]        m_rdata
);

   typedef enum logic [1:0] {IDLE, XFER, LAST, DONE} state_t;

   state_t            state_reg, state_next;
   logic [1:0]        cnt_reg, cnt_next;
   logic [1:0]        last_idx_reg;     // N-1 for the accepted request
   logic              sel_data_reg;     // 1 = data port owns the current transfer
   logic              last_grant_reg;   // 1 = data port was granted last
   logic              we_reg;
   logic [2:0]        funct3_reg;
   logic [ADDR_W-1:0] base_reg;
   logic [31:0]       wdata_reg;
   logic              err_reg;
   logic [31:0]       asm_reg;          // assembled load bytes
   logic              cap_reg;          // a read byte arrives this cycle
   logic [1:0]        cap_idx_reg;      // which assembly byte it belongs to
   logic [3:0]        cap_hit;

   // Winner of this IDLE cycle and the properties of its request
   logic              any_req, grant_data, req_we, req_err, illegal, misalign;
   logic [2:0]        req_f3;
   logic [ADDR_W-1:0] req_addr;
   logic [1:0]        req_last;
   logic              accept;

   assign any_req    = if_req || d_req;
   assign grant_data = d_req && (!if_req || !last_grant_reg);
   assign req_f3     = grant_data ? d_funct3 : 3'b010;
   assign req_we     = grant_data && d_we;
   assign req_addr   = grant_data ? d_addr : if_addr;
   assign accept     = (state_reg == IDLE) && any_req;

   // Legality, alignment and byte count of the winning request
   always_comb begin
      illegal  = 1'b0;
      misalign = 1'b0;
      req_last = 2'd3;
      if (grant_data) begin
         if (req_we)
            illegal = !(req_f3 inside {3'b000, 3'b001, 3'b010});
         else
            illegal = !(req_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      end
      case (req_f3[1:0])
         2'b00:   req_last = 2'd0;
         2'b01:   begin req_last = 2'd1; misalign = req_addr[0]; end
         default: begin req_last = 2'd3; misalign = (req_addr[1:0] != 2'b00); end
      endcase
   end

   assign req_err = illegal || misalign;

   // Next-state and byte counter sequencing
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         IDLE: begin
            cnt_next = 2'd0;
            if (any_req)
               state_next = req_err ? DONE : XFER;
         end
         XFER: begin
            if (cnt_reg == last_idx_reg) begin
               state_next = we_reg ? DONE : LAST;
               cnt_next   = 2'd0;
            end else begin
               cnt_next = cnt_reg + 2'd1;
            end
         end
         LAST:    state_next = DONE;
         default: state_next = IDLE;
      endcase
   end

   // State register, request latch and round-robin pointer
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         cnt_reg        <= 2'd0;
         last_idx_reg   <= 2'd0;
         sel_data_reg   <= 1'b0;
         last_grant_reg <= 1'b0;
         we_reg         <= 1'b0;
         funct3_reg     <= 3'b000;
         base_reg       <= '0;
         wdata_reg      <= 32'h0;
         err_reg        <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         if (accept) begin
            sel_data_reg <= grant_data;
            we_reg       <= req_we;
            funct3_reg   <= req_f3;
            base_reg     <= req_addr;
            wdata_reg    <= d_wdata;
            err_reg      <= req_err;
            last_idx_reg <= req_last;
         end
         if (state_reg == DONE)
            last_grant_reg <= sel_data_reg;
      end
   end

   // One-hot byte lane for the read byte returning this cycle
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_cap
         assign cap_hit[gi] = cap_reg && (cap_idx_reg == 2'(gi));
      end
   endgenerate

   // Read capture: the byte issued last cycle lands in its assembly lane
   always_ff @(posedge clk) begin
      if (rst) begin
         cap_reg     <= 1'b0;
         cap_idx_reg <= 2'd0;
         asm_reg     <= 32'h0;
      end else begin
         cap_reg     <= (state_reg == XFER) && !we_reg;
         cap_idx_reg <= cnt_reg;
         if (accept) begin
            asm_reg <= 32'h0;
         end else begin
            for (int i = 0; i < 4; i++)
               if (cap_hit[i])
                  asm_reg[8*i +: 8] <= m_rdata;
         end
      end
   end

   // Load extension of the assembled bytes
   logic [31:0] ext_data;
   always_comb begin
      ext_data = asm_reg;
      case (funct3_reg)
         3'b000:  ext_data = {{24{asm_reg[7]}}, asm_reg[7:0]};
         3'b100:  ext_data = {24'h0, asm_reg[7:0]};
         3'b001:  ext_data = {{16{asm_reg[15]}}, asm_reg[15:0]};
         3'b101:  ext_data = {16'h0, asm_reg[15:0]};
         default: ext_data = asm_reg;
      endcase
   end

   // Outputs are forced quiet while reset is held so an aborted store
   // writes nothing in the reset cycle.
   logic done;
   assign done     = !rst && (state_reg == DONE);
   assign m_en     = !rst && (state_reg == XFER);
   assign m_we     = m_en && we_reg;
   assign m_addr   = m_en ? base_reg + ADDR_W'(cnt_reg) : '0;
   assign m_wdata  = m_we ? wdata_reg[8*cnt_reg +: 8] : 8'h0;
   assign if_ack   = done && !sel_data_reg;
   assign d_ack    = done && sel_data_reg;
   assign if_err   = if_ack && err_reg;
   assign d_err    = d_ack && err_reg;
   assign if_rdata = (if_ack && !err_reg) ? asm_reg : 32'h0;
   assign d_rdata  = (d_ack && !err_reg && !we_reg) ? ext_data : 32'h0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a byte-wide synchronous-read
// memory model behind the memory port.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, d_req, d_we;
   logic [5:0]  if_addr, d_addr;
   logic [2:0]  d_funct3;
   logic [31:0] d_wdata;
   logic [31:0] if_rdata, d_rdata;
   logic        if_ack, if_err, d_ack, d_err;
   logic        m_en, m_we;
   logic [5:0]  m_addr;
   logic [7:0]  m_wdata, m_rdata;

   logic [7:0]  mem [64];
   logic        bd_we;
   logic [5:0]  bd_addr;
   logic [7:0]  bd_data;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(6)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
      .if_ack(if_ack), .if_err(if_err),
      .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr),
      .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
      .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_rdata(m_rdata)
   );

   // Byte memory with synchronous read and a backdoor for preloading
   always @(posedge clk) begin
      if (bd_we)
         mem[bd_addr] <= bd_data;
      else if (m_en && m_we)
         mem[m_addr] <= m_wdata;
      if (m_en && !m_we)
         m_rdata <= mem[m_addr];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // One transaction on either port, started in an IDLE cycle (cycle 0)
   task automatic xact(input string name, input bit is_data, input logic we,
                       input logic [2:0] f3, input logic [5:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rd,
                       input logic exp_err, input int exp_cyc, input int exp_men);
      int  cyc = 0;
      int  men = 0;
      int  xport = 0;
      int  bad_we = 0;
      bit  got = 0;
      logic [31:0] rd = 32'h0;
      logic        er = 1'b0;
      if (is_data) begin
         d_we = we; d_funct3 = f3; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
      end else begin
         if_addr = addr; if_req = 1'b1;
      end
      for (int c = 1; c <= 20 && !got; c++) begin
         @(posedge clk); #1;
         if (m_en) begin
            men++;
            if (m_we !== we) bad_we++;
         end
         if (is_data ? if_ack : d_ack) xport++;
         if (is_data ? d_ack : if_ack) begin
            got = 1; cyc = c;
            rd = is_data ? d_rdata : if_rdata;
            er = is_data ? d_err : if_err;
         end
      end
      d_req = 1'b0; if_req = 1'b0;
      chk({name, " ack_cycle"}, cyc, exp_cyc);
      chk({name, " rdata"}, rd, exp_rd);
      chk({name, " err"}, {31'h0, er}, {31'h0, exp_err});
      chk({name, " m_en_count"}, men, exp_men);
      chk({name, " xport_quiet"}, xport + bad_we, 0);
      @(posedge clk); #1;
   endtask

   typedef struct {
      string       name;
      logic        we;
      logic [2:0]  f3;
      logic [5:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic        exp_err;
      int          exp_cyc;
      int          exp_men;
   } vec_t;

   vec_t vecs [18];

   initial begin
      int c;
      int nack;
      int gap;
      bit exp_port [4];
      logic [31:0] exp_val [4];

      vecs[0]  = '{"SW08",    1'b1, 3'b010, 6'h08, 32'hA1B2C3D4, 32'h00000000, 1'b0, 5, 4};
      vecs[1]  = '{"LW08",    1'b0, 3'b010, 6'h08, 32'h0,        32'hA1B2C3D4, 1'b0, 6, 4};
      vecs[2]  = '{"SB10",    1'b1, 3'b000, 6'h10, 32'h00000080, 32'h00000000, 1'b0, 2, 1};
      vecs[3]  = '{"SB11",    1'b1, 3'b000, 6'h11, 32'h123456FF, 32'h00000000, 1'b0, 2, 1};
      vecs[4]  = '{"LB10",    1'b0, 3'b000, 6'h10, 32'h0,        32'hFFFFFF80, 1'b0, 3, 1};
      vecs[5]  = '{"LBU10",   1'b0, 3'b100, 6'h10, 32'h0,        32'h00000080, 1'b0, 3, 1};
      vecs[6]  = '{"LH10",    1'b0, 3'b001, 6'h10, 32'h0,        32'hFFFFFF80, 1'b0, 4, 2};
      vecs[7]  = '{"LHU10",   1'b0, 3'b101, 6'h10, 32'h0,        32'h0000FF80, 1'b0, 4, 2};
      vecs[8]  = '{"LW05err", 1'b0, 3'b010, 6'h05, 32'h0,        32'h00000000, 1'b1, 1, 0};
      vecs[9]  = '{"F3_011",  1'b0, 3'b011, 6'h00, 32'h0,        32'h00000000, 1'b1, 1, 0};
      vecs[10] = '{"SF3_100", 1'b1, 3'b100, 6'h00, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1, 0};
      vecs[11] = '{"LH11err", 1'b0, 3'b001, 6'h11, 32'h0,        32'h00000000, 1'b1, 1, 0};
      vecs[12] = '{"SW3C",    1'b1, 3'b010, 6'h3C, 32'h11223344, 32'h00000000, 1'b0, 5, 4};
      vecs[13] = '{"LBU3F",   1'b0, 3'b100, 6'h3F, 32'h0,        32'h00000011, 1'b0, 3, 1};
      vecs[14] = '{"LW3C",    1'b0, 3'b010, 6'h3C, 32'h0,        32'h11223344, 1'b0, 6, 4};
      vecs[15] = '{"SH20",    1'b1, 3'b001, 6'h20, 32'hDEADBEEF, 32'h00000000, 1'b0, 3, 2};
      vecs[16] = '{"LW20",    1'b0, 3'b010, 6'h20, 32'h0,        32'h7978BEEF, 1'b0, 6, 4};
      vecs[17] = '{"LB21",    1'b0, 3'b000, 6'h21, 32'h0,        32'hFFFFFFBE, 1'b0, 3, 1};

      rst = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_funct3 = 3'b000;
      if_addr = 6'h0; d_addr = 6'h0; d_wdata = 32'h0;
      bd_we = 1'b0; bd_addr = 6'h0; bd_data = 8'h0;

      // Preload mem[i] = i ^ 0x5A while held in reset
      for (int i = 0; i < 64; i++) begin
         @(posedge clk); #1;
         bd_we = 1'b1; bd_addr = 6'(i); bd_data = 8'(i) ^ 8'h5A;
      end
      @(posedge clk); #1;
      bd_we = 1'b0;

      // Reset with both requesters active: everything stays quiet
      d_we = 1'b0; d_funct3 = 3'b010; d_addr = 6'h00; d_req = 1'b1;
      if_addr = 6'h04; if_req = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         chk("reset_ctl", {26'h0, if_ack, d_ack, if_err, d_err, m_en, m_we}, 32'h0);
         chk("reset_data", if_rdata | d_rdata | {18'h0, m_addr, m_wdata}, 32'h0);
      end

      // Release: data wins the first tie, then grants alternate
      exp_port[0] = 1'b1; exp_port[1] = 1'b0; exp_port[2] = 1'b1; exp_port[3] = 1'b0;
      for (int i = 0; i < 4; i++)
         exp_val[i] = exp_port[i] ? 32'h59585B5A : 32'h5D5C5F5E;
      rst = 1'b0;
      nack = 0; gap = 0; c = 0;
      while (nack < 4 && c < 100) begin
         @(posedge clk); #1;
         c++;
         if (gap == 2) begin
            chk("rr_next_m_en", {31'h0, m_en}, 32'h1);
            gap = 0;
         end
         if (gap == 1) begin
            chk("rr_gap_idle", {30'h0, m_en, if_ack | d_ack}, 32'h0);
            gap = 2;
         end
         if (if_ack || d_ack) begin
            if (nack == 0) chk("rr_first_ack_cycle", c, 6);
            chk("rr_port", {30'h0, d_ack, if_ack}, exp_port[nack] ? 32'h2 : 32'h1);
            chk("rr_rdata", d_ack ? d_rdata : if_rdata, exp_val[nack]);
            nack++;
            gap = 1;
         end
      end
      chk("rr_ack_count", nack, 4);
      if_req = 1'b0; d_req = 1'b0;
      @(posedge clk); #1;

      // Table-driven data-port transactions
      for (int i = 0; i < 18; i++)
         xact(vecs[i].name, 1'b1, vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
              vecs[i].exp_rd, vecs[i].exp_err, vecs[i].exp_cyc, vecs[i].exp_men);

      chk("mem08", {24'h0, mem[6'h08]}, 32'hD4);
      chk("mem0B", {24'h0, mem[6'h0B]}, 32'hA1);
      chk("mem3C", {24'h0, mem[6'h3C]}, 32'h44);
      chk("mem3F", {24'h0, mem[6'h3F]}, 32'h11);
      chk("mem00_nowrap", {24'h0, mem[6'h00]}, 32'h5A);

      // Fetch port
      xact("IF08",    1'b0, 1'b0, 3'b010, 6'h08, 32'h0, 32'hA1B2C3D4, 1'b0, 6, 4);
      xact("IF02err", 1'b0, 1'b0, 3'b010, 6'h02, 32'h0, 32'h00000000, 1'b1, 1, 0);

      // Abort a word store in its second byte cycle
      d_we = 1'b1; d_funct3 = 3'b010; d_addr = 6'h30; d_wdata = 32'h99887766; d_req = 1'b1;
      @(posedge clk); #1;
      chk("abort_c1_m_en", {31'h0, m_en}, 32'h1);
      chk("abort_c1_addr", {26'h0, m_addr}, 32'h30);
      @(posedge clk); #1;
      rst = 1'b1; d_req = 1'b0;
      #1;
      chk("abort_rst_m_en", {31'h0, m_en}, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("abort_quiet", {30'h0, m_en, d_ack}, 32'h0);
         @(posedge clk); #1;
      end
      chk("abort_mem30", {24'h0, mem[6'h30]}, 32'h66);
      chk("abort_mem31", {24'h0, mem[6'h31]}, 32'h6B);
      xact("LBU30", 1'b1, 1'b0, 3'b100, 6'h30, 32'h0, 32'h00000066, 1'b0, 3, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
